// File: rtl/hamming_display_sched_pkg.sv
// Shared types, display codes and helpers for the Hamming decoder display scheduler.
package hamming_disp_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    typedef enum logic {
        PG_RAW  = 1'b0,
        PG_CORR = 1'b1
    } page_t;

    localparam logic [1:0] AN_POS0  = 2'b10;
    localparam logic [1:0] AN_POS1  = 2'b01;
    localparam logic [1:0] AN_OFF   = 2'b11;
    localparam logic [3:0] ERR_CODE = 4'hE;

    typedef struct packed {
        logic [3:0] rx;
        logic [2:0] syn;
        logic [3:0] corr;
    } snap_t;

    // Bits needed to hold 0..term.
    function automatic int unsigned cnt_width(input longint unsigned term);
        return (term == 0) ? 1 : $clog2(term + 1);
    endfunction

    function automatic logic [3:0] slot_code(input logic pos, input page_t pg, input snap_t s);
        if (!pos) return (pg == PG_RAW) ? s.rx : s.corr;
        if (pg == PG_RAW) return {1'b0, s.syn};
        return (s.syn != 3'd0) ? ERR_CODE : 4'h0;
    endfunction

endpackage

// File: rtl/hamming_display_sched_if.sv
// Decoder-result handshake bus between the Hamming decoder and the display scheduler.
interface hamming_display_sched_if;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] rx_word;
    logic [2:0] syndrome;
    logic [3:0] corr_word;

    modport master (output res_valid, rx_word, syndrome, corr_word, input res_ready);
    modport slave  (input res_valid, rx_word, syndrome, corr_word, output res_ready);
endinterface

// File: rtl/hamming_display_sched_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, rising-edge pulse.
module btn_debounce
    import hamming_disp_pkg::*;
#(
    parameter int unsigned STABLE_CYC = 540000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic next_req
);
    localparam int unsigned CNT_W = cnt_width(64'(STABLE_CYC) - 64'd1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            level    <= 1'b0;
            cnt      <= '0;
            next_req <= 1'b0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            next_req <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(64'(STABLE_CYC) - 64'd1)) begin
                cnt      <= '0;
                level    <= sync2;
                next_req <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hamming_display_sched.sv
// Two-digit multiplexed 7-seg scheduler for the Hamming decoder board.
// Optional pos1 error blink is built when HAMMING_ERR_BLINK_EN is defined.
module hamming_display_sched
    import hamming_disp_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 27000000,
    parameter int unsigned SLOT_HZ     = 1000,
    parameter int unsigned BLANK_CYC   = 270,
    parameter int unsigned PAGE_MS     = 2000,
    parameter int unsigned DEBOUNCE_MS = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    hamming_display_sched_if.slave  res,
    input  logic                    btn_next,
    input  logic                    auto_en,
    output logic [3:0]              digit,
    output logic [1:0]              an,
    output logic                    page
);
    localparam longint unsigned SLOT_CYC = 64'(CLK_HZ / SLOT_HZ);
    localparam longint unsigned PAGE_CYC = 64'(PAGE_MS) * 64'(CLK_HZ) / 64'd1000;
    localparam longint unsigned DEB_CYC  = 64'(DEBOUNCE_MS) * 64'(CLK_HZ) / 64'd1000;
    localparam int unsigned     SLOT_W   = cnt_width(SLOT_CYC - 64'd1);
    localparam int unsigned     PAGE_W   = cnt_width(PAGE_CYC - 64'd1);

    scan_state_t       state_q, state_d;
    logic [SLOT_W-1:0] cnt_q, cnt_d;
    logic              pos_q, pos_d;
    logic [1:0]        an_d;
    logic [3:0]        digit_d;
    logic              ready_q, ready_d;
    snap_t             snap_q, snap_d;
    page_t             page_q, page_d;
    page_t             disp_q, disp_d;
    logic [PAGE_W-1:0] tmr_q, tmr_d;
    logic              accept;
    logic              next_req;

`ifdef HAMMING_ERR_BLINK_EN
    localparam longint unsigned BLINK_HALF = 64'(CLK_HZ / 4);
    localparam int unsigned     BLINK_W    = cnt_width(BLINK_HALF - 64'd1);
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_off_q, blink_off_d;
`endif

    btn_debounce #(
        .STABLE_CYC (32'(DEB_CYC))
    ) u_btn (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn_next),
        .next_req (next_req)
    );

    assign res.res_ready = ready_q;
    assign page          = page_q;

    always_comb begin
        accept  = res.res_valid & ready_q;
        snap_d  = snap_q;
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        pos_d   = pos_q;
        an_d    = an;
        digit_d = digit;
        disp_d  = disp_q;
        page_d  = page_q;
        tmr_d   = tmr_q;

        if (accept) snap_d = '{rx: res.rx_word, syn: res.syndrome, corr: res.corr_word};

        if (accept) begin
            page_d = PG_RAW;
            tmr_d  = '0;
        end else if (next_req) begin
            page_d = (page_q == PG_RAW) ? PG_CORR : PG_RAW;
            tmr_d  = '0;
        end else if (!auto_en) begin
            tmr_d = '0;
        end else if (tmr_q == PAGE_W'(PAGE_CYC - 64'd1)) begin
            page_d = (page_q == PG_RAW) ? PG_CORR : PG_RAW;
            tmr_d  = '0;
        end else begin
            tmr_d = tmr_q + 1'b1;
        end

`ifdef HAMMING_ERR_BLINK_EN
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_off_d = blink_off_q;
        if (accept) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_HALF - 64'd1)) begin
            blink_cnt_d = '0;
            blink_off_d = ~blink_off_q;
        end
`endif

        // Digit content is resolved on SHOW entry using the snapshot as it will be
        // after this edge, so a result accepted in the last BLANK cycle is shown.
        if (cnt_q == SLOT_W'(SLOT_CYC - 64'd1)) begin
            cnt_d   = '0;
            pos_d   = ~pos_q;
            state_d = BLANK;
            an_d    = AN_OFF;
            digit_d = '0;
            disp_d  = page_d;
        end else if (state_q == BLANK && cnt_q == SLOT_W'(64'(BLANK_CYC) - 64'd1)) begin
            state_d = SHOW;
            an_d    = pos_q ? AN_POS1 : AN_POS0;
            digit_d = slot_code(pos_q, disp_q, snap_d);
`ifdef HAMMING_ERR_BLINK_EN
            if (pos_q && snap_d.syn != 3'd0 && blink_off_q) an_d = AN_OFF;
`endif
        end

        ready_d = (state_d == BLANK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            pos_q   <= 1'b0;
            an      <= AN_OFF;
            digit   <= '0;
            ready_q <= 1'b0;
            snap_q  <= '0;
            page_q  <= PG_RAW;
            disp_q  <= PG_RAW;
            tmr_q   <= '0;
`ifdef HAMMING_ERR_BLINK_EN
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            an      <= an_d;
            digit   <= digit_d;
            ready_q <= ready_d;
            snap_q  <= snap_d;
            page_q  <= page_d;
            disp_q  <= disp_d;
            tmr_q   <= tmr_d;
`ifdef HAMMING_ERR_BLINK_EN
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
`endif
        end
    end

endmodule

// File: tb/tb_hamming_display_sched.sv
// Self-checking bench for hamming_display_sched with a cycle-count based reference model.
module tb_hamming_display_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_next;
    logic       auto_en;
    logic [3:0] digit;
    logic [1:0] an;
    logic       page;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hamming_display_sched_if bus ();

    hamming_display_sched #(
        .CLK_HZ      (1000),
        .SLOT_HZ     (100),
        .BLANK_CYC   (2),
        .PAGE_MS     (100),
        .DEBOUNCE_MS (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .res      (bus),
        .btn_next (btn_next),
        .auto_en  (auto_en),
        .digit    (digit),
        .an       (an),
        .page     (page)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slot position derived from cycles since reset (10-cycle slots,
    // 2 blank cycles), page/timer/debounce from the written rules.
    bit         m_started = 1'b0;
    int         m_k;
    logic [3:0] m_rx, m_corr, m_shown;
    logic [2:0] m_syn;
    bit         m_page, m_disp, m_pos1_off;
    int         m_tmr, m_run, m_b;
    bit         m_s1, m_s2, m_lvl, m_nreq;

    always @(posedge clk) begin
        int  cnt;
        bit  rdy, acc, nreq_new, off_pre;
        if (rst) begin
            m_started = 1'b1;
            m_k = 0; m_rx = '0; m_syn = '0; m_corr = '0; m_shown = '0;
            m_page = 0; m_disp = 0; m_pos1_off = 0; m_tmr = 0; m_run = 0; m_b = 0;
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_nreq = 0;
        end else if (m_started) begin
            cnt = m_k % 10;
            rdy = (cnt < 2) && (m_k != 0);
            acc = bus.res_valid && rdy;
            if (acc) begin
                m_page = 0; m_tmr = 0;
            end else if (m_nreq) begin
                m_page = !m_page; m_tmr = 0;
            end else if (!auto_en) begin
                m_tmr = 0;
            end else if (m_tmr == 99) begin
                m_page = !m_page; m_tmr = 0;
            end else begin
                m_tmr++;
            end
            nreq_new = 0;
            if (m_s2 != m_lvl) begin
                if (m_run == 4) begin m_lvl = m_s2; m_run = 0; nreq_new = m_s2; end
                else m_run++;
            end else m_run = 0;
            m_nreq = nreq_new;
            m_s2 = m_s1;
            m_s1 = btn_next;
            off_pre = ((m_b / 250) % 2) == 1;
            if (acc) begin
                m_rx = bus.rx_word; m_syn = bus.syndrome; m_corr = bus.corr_word; m_b = 0;
            end else m_b++;
            m_k++;
            if (m_k % 10 == 0) m_disp = m_page;
            if (m_k % 10 == 2) begin
                if ((m_k / 10) % 2 == 0) begin
                    m_shown = m_disp ? m_corr : m_rx;
                    m_pos1_off = 0;
                end else begin
                    m_shown = m_disp ? ((m_syn != 0) ? 4'hE : 4'h0) : {1'b0, m_syn};
`ifdef HAMMING_ERR_BLINK_EN
                    m_pos1_off = (m_syn != 0) && off_pre;
`else
                    m_pos1_off = 0;
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        int         cnt, pos;
        logic [1:0] ea;
        logic [3:0] ed;
        if (m_started) begin
            cnt = m_k % 10;
            pos = (m_k / 10) % 2;
            ea  = (cnt < 2) ? 2'b11 : (pos == 1 ? (m_pos1_off ? 2'b11 : 2'b01) : 2'b10);
            ed  = (cnt < 2) ? 4'h0 : m_shown;
            chk("an", int'(an), int'(ea));
            chk("digit", int'(digit), int'(ed));
            chk("res_ready", int'(bus.res_ready), int'((cnt < 2) && (m_k != 0)));
            chk("page", int'(page), int'(m_page));
        end
    end

    task automatic wait_slot(input int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((m_k % 10) == 5 && ((m_k / 10) % 2) == p) && n < 40);
        if (n >= 40) chk("wait_slot_timeout", 0, 1);
    endtask

    task automatic send(input logic [3:0] rx, input logic [2:0] syn, input logic [3:0] corr);
        int n = 0;
        bus.rx_word = rx; bus.syndrome = syn; bus.corr_word = corr;
        bus.res_valid = 1'b1;
        while (!bus.res_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) chk("handshake_timeout", 0, 1);
        @(negedge clk);
        bus.res_valid = 1'b0;
    endtask

    task automatic press(input int len);
        btn_next = 1'b1;
        repeat (len) @(negedge clk);
        btn_next = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; btn_next = 1'b0; auto_en = 1'b0;
        bus.res_valid = 1'b0; bus.rx_word = '0; bus.syndrome = '0; bus.corr_word = '0;
        repeat (2) @(negedge clk);
        chk("rst_an", int'(an), 3);
        chk("rst_digit", int'(digit), 0);
        chk("rst_page", int'(page), 0);
        chk("rst_ready", int'(bus.res_ready), 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Result raised mid-SHOW: must wait for BLANK.
        n = 0;
        while (m_k % 10 != 5 && n < 20) begin @(negedge clk); n++; end
        chk("s2_in_show_not_ready", int'(bus.res_ready), 0);
        send(4'hA, 3'b101, 4'hB);
        wait_slot(0);
        chk("s2_pos0_digit", int'(digit), 4'hA);
        chk("s2_pos0_an", int'(an), 2);
        wait_slot(1);
        chk("s2_pos1_digit", int'(digit), 4'h5);
        chk("s2_pos1_an", int'(an), 1);
        chk("s2_page", int'(page), 0);

        press(8);
        repeat (30) @(negedge clk);
        chk("s3_page", int'(page), 1);
        wait_slot(0);
        chk("s3_pos0_digit", int'(digit), 4'hB);
        wait_slot(1);
        chk("s3_pos1_digit", int'(digit), 4'hE);

        press(3);
        repeat (20) @(negedge clk);
        chk("s4_glitch_page", int'(page), 1);

        auto_en = 1'b1;
        repeat (250) @(negedge clk);
        send(4'h3, 3'b000, 4'h3);
        n = 0;
        while (m_tmr != 99 && n < 150) begin @(negedge clk); n++; end
        if (n >= 150) chk("s5_expiry_timeout", 0, 1);
        chk("s5_coincide_ready", int'(bus.res_ready), 1);
        send(4'h4, 3'b000, 4'h4);
        chk("s5_accept_wins", int'(page), 0);
        repeat (50) @(negedge clk);
        chk("s5_timer_cleared", int'(page), 0);
        repeat (60) @(negedge clk);
        chk("s5_auto_toggle", int'(page), 1);

        auto_en = 1'b0;
        repeat (5) @(negedge clk);
        send(4'hC, 3'b011, 4'hD);
        press(8);
        repeat (20) @(negedge clk);
        chk("s6_page_before", int'(page), 1);
        n = 0;
        while (m_k % 10 != 5 && n < 20) begin @(negedge clk); n++; end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("s6_an", int'(an), 3);
        chk("s6_digit", int'(digit), 0);
        chk("s6_page", int'(page), 0);
        chk("s6_ready", int'(bus.res_ready), 0);
        wait_slot(0);
        chk("s6_snap_pos0", int'(digit), 0);
        wait_slot(1);
        chk("s6_snap_pos1", int'(digit), 0);

        send(4'h7, 3'b110, 4'h6);
        repeat (600) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
